// File: rtl/freq_div_controller.sv
// freq_div_controller: programmable clock divider with free-running/one-shot modes, pause/resume and abort
module freq_div_controller #(
  parameter int WIDTH = 32,
  parameter int NW = 8,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(25000000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [NW-1:0]    cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             div_clk,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] period_r, cnt;
  logic [NW-1:0] left_r;
  logic oneshot_r, hs, due, last, zero_shot, go;
  always_comb begin
    hs = cfg_valid && cfg_ready;
    due = cnt == period_r;
    last = due && oneshot_r && left_r == NW'(1);
    zero_shot = (hs ? cfg_oneshot : oneshot_r) && (hs ? cfg_count : left_r) == '0;
    go = start && !stop;
    state_n = state;
    case (state)
      IDLE:    state_n = go && !zero_shot ? RUN : IDLE;
      RUN:     state_n = last ? IDLE : stop ? PAUSE : RUN;
      PAUSE:   state_n = stop ? IDLE : start ? RUN : PAUSE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // a tick due on the pausing edge is still issued; the counter then parks at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      period_r <= DEFAULT_PERIOD;
      oneshot_r <= 1'b0;
      left_r <= '0;
      cnt <= '0;
      tick <= 1'b0;
      div_clk <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      busy <= state_n != IDLE;
      cfg_ready <= state_n == IDLE;
      if (hs) begin
        period_r <= cfg_period;
        oneshot_r <= cfg_oneshot;
        left_r <= cfg_count;
      end
      if (state == IDLE && go) begin
        cnt <= '0;
        done <= zero_shot;
      end
      if (state == RUN) begin
        if (due) begin
          cnt <= '0;
          tick <= 1'b1;
          div_clk <= ~div_clk;
          done <= last;
          if (oneshot_r) left_r <= left_r - NW'(1);
        end else if (!stop) cnt <= cnt + WIDTH'(1);
      end
      if (state == PAUSE && stop) begin
        cnt <= '0;
        div_clk <= 1'b0;
        left_r <= '0;
      end
    end
  end
endmodule

// File: doc/freq_div_controller.md
# freq_div_controller

Programmable controller for the lab's clock-divider datapath. It owns the shared divider counter and sequences it for a host FSM:
- accepts a period/mode configuration through a valid/ready handshake;
- starts, pauses and aborts the divider on command;
- emits a single-cycle `tick` and a toggling `div_clk`, in either free-running or N-tick one-shot mode.

It sits between the top-level control FSM (buttons/keypad decode) and the display/LED logic that consumes slow ticks.

## Interface
- `WIDTH`, 32 — width of the divider counter and period register.
- `NW`, 8 — width of the one-shot tick-count field.
- `DEFAULT_PERIOD`, 32'd25000000 — period loaded at reset.

Ports:
- `clk` in 1 — sole clock; all logic on posedge.
- `reset` in 1 — synchronous, active-high reset.
- `cfg_valid` in 1 — configuration offered.
- `cfg_ready` out 1 — configuration can be accepted; high only in IDLE.
- `cfg_period` in WIDTH — tick interval minus one, in `clk` cycles.
- `cfg_oneshot` in 1 — 0 selects free-running mode; 1 selects one-shot mode.
- `cfg_count` in NW — number of ticks in one-shot mode.
- `start` in 1 — level-sampled run/resume command.
- `stop` in 1 — level-sampled pause/abort command.
- `tick` out 1 — one-cycle pulse per elapsed period.
- `div_clk` out 1 — toggles on every tick.
- `busy` out 1 — high in RUN or PAUSE.
- `done` out 1 — one-cycle pulse when a one-shot run completes.

## Operation

**States:** IDLE, RUN, PAUSE. Reset enters IDLE.

**Reset values:**
- `period_r` = `DEFAULT_PERIOD`; `oneshot_r` = 0; `left_r` = 0; counter = 0.
- Outputs: `tick` = 0, `div_clk` = 0, `done` = 0, `busy` = 0, `cfg_ready` = 1.

**Configuration:**
- A handshake (`cfg_valid` && `cfg_ready`) latches `period_r`, `oneshot_r` and `left_r` (← `cfg_count`).
- Outside IDLE, `cfg_valid` is ignored. The requester holds `cfg_valid` until it sees `cfg_ready`.

**IDLE:**
- `start` → RUN with counter = 0.
- A handshake and `start` in the same cycle: the run uses the new configuration.
- One-shot mode with `left` = 0 (new value if a handshake occurs that cycle) and `start`: remain in IDLE and pulse `done` on the next cycle.

**RUN:**
- counter != `period_r`: counter += 1.
- counter == `period_r`: counter ← 0, `tick` ← 1, `div_clk` ← ~`div_clk`.
- One-shot mode: each tick decrements `left_r`. The tick that takes `left_r` from 1 to 0 also sets `done` ← 1 and returns to IDLE.
- Free-running mode: runs until `stop`.

**`stop` handling:**
- `stop` in RUN → PAUSE. Counter, `left_r` and `div_clk` hold.
- If a tick is due on that same edge, the tick is still issued and PAUSE holds counter = 0.
- `stop` in PAUSE → IDLE (abort): counter ← 0, `div_clk` ← 0, `left_r` ← 0, no `done`.
- `start` in PAUSE → RUN, resuming from the held counter value.
- `start` and `stop` together: `stop` wins in every state.

**Other rules:**
- `cfg_period` = 0 is legal: one tick per `clk` in RUN.
- Counter compare is an exact WIDTH-bit equality. The counter never exceeds `period_r`, so it never wraps.

## Timing
- All outputs are registered.
- `start` sampled at edge T → `busy` = 1 and counter = 0 from T+1.
- First `tick` is high in cycle T+2+`period`. Subsequent ticks occur every `period`+1 cycles.
- `div_clk` changes on the same edge that raises `tick`. Full `div_clk` period = 2·(`period`+1) `clk` cycles.
- One-shot mode: `done` coincides with the final `tick`. `busy` and `cfg_ready` change on that same edge (`busy` falls, `cfg_ready` rises).
- `cfg_ready` falls on the edge that enters RUN and rises on the edge that enters IDLE.
- A handshake takes effect on the next edge.
- `reset` asserted in any state returns all state to reset values on the next edge. It overrides `start`, `stop` and `cfg`.

## Test plan
- Free-run: reset; cfg `period` = 3, `oneshot` = 0; `start` one cycle → `tick` every 4 cycles, first at start+5; `div_clk` period 8; `busy` = 1.
- One-shot: `period` = 1, `count` = 3 → exactly 3 ticks, 2 cycles apart. `done` together with the 3rd tick; then `busy` = 0 and `cfg_ready` = 1.
- Pause/resume: `period` = 9; `stop` when counter = 5 → no ticks while paused, counter stays 5. `start` → next tick 5 cycles after resume (counter 5 reaches 9 after four increments, registered tick one edge later).
- Abort: `stop` in RUN, then `stop` in PAUSE → IDLE, `div_clk` = 0, no `done`. `cfg_valid` accepted on the next cycle.
- Corners:
  - `period` = 0 → `tick` high every cycle.
  - `start` + `stop` together → no state change from IDLE.
  - One-shot with `count` = 0 → `done` pulse only.
  - `cfg_valid` in RUN → `cfg_ready` = 0, `period_r` unchanged.
- Reset mid-run (`period` = 7, counter = 4): `reset` high one cycle → next cycle all outputs at reset values, `period_r` = `DEFAULT_PERIOD`.
